// File: rtl/ula_arbiter_if.sv
// Requester handshakes, shared result and ULA operand bus for ula_arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters'/ULA side.
interface ula_arbiter_if;
  logic       req_valid0, req_valid1;
  logic       req_ready0, req_ready1;
  logic [3:0] req_a0, req_a1;
  logic [3:0] req_b0, req_b1;
  logic [2:0] req_op0, req_op1;
  logic       rsp_valid0, rsp_valid1;
  logic       rsp_ready0, rsp_ready1;
  logic [7:0] rsp_s;
  logic [3:0] ula_a, ula_b;
  logic [2:0] ula_op;
  logic [7:0] ula_s;
  logic       busy;

  modport slave (
    input  req_valid0, req_valid1, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
    input  rsp_ready0, rsp_ready1, ula_s,
    output req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_s,
    output ula_a, ula_b, ula_op, busy
  );

  modport master (
    output req_valid0, req_valid1, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
    output rsp_ready0, rsp_ready1, ula_s,
    input  req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_s,
    input  ula_a, ula_b, ula_op, busy
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two requesters.
// Operands are registered for a full EXEC cycle, and the result is held until the owner takes it.
module ula_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  ula_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] a_r, b_r;
  logic [2:0] op_r;
  logic [7:0] s_r;
  logic       owner, prio;
  logic       any_valid, winner, accept, rsp_taken;

  // On a tie, prio picks the winner. Otherwise the only valid requester wins.
  always_comb begin
    any_valid = bus.req_valid0 | bus.req_valid1;
    winner    = (bus.req_valid0 & bus.req_valid1) ? prio : bus.req_valid1;
    accept    = (state == IDLE) & any_valid;
    rsp_taken = (state == RESP) & (owner ? bus.rsp_ready1 : bus.rsp_ready0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
      s_r   <= '0;
      owner <= 1'b0;
      prio  <= 1'b0;
    end else begin
      if (accept) begin
        owner <= winner;
        a_r   <= winner ? bus.req_a1  : bus.req_a0;
        b_r   <= winner ? bus.req_b1  : bus.req_b0;
        op_r  <= winner ? bus.req_op1 : bus.req_op0;
      end
      if (state == EXEC) s_r <= bus.ula_s;
      if (rsp_taken)     prio <= ~owner;
    end
  end

  // The ready signals are gated by rst_n so that no accept is signalled while reset is held.
  always_comb begin
    bus.req_ready0 = rst_n & accept & ~winner;
    bus.req_ready1 = rst_n & accept & winner;
    bus.rsp_valid0 = (state == RESP) & ~owner;
    bus.rsp_valid1 = (state == RESP) & owner;
    bus.rsp_s      = s_r;
    bus.ula_a      = a_r;
    bus.ula_b      = b_r;
    bus.ula_op     = op_r;
    bus.busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of round-robin grant and the stub ULA.
module tb_ula_arbiter;

  logic clk;
  logic rst_n;
  int unsigned total;
  int unsigned bad;
  logic m_prio;

  ula_arbiter_if bus ();

  assign bus.ula_s = {1'b0, bus.ula_op, 4'(bus.ula_a + bus.ula_b)};

  ula_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ula_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return {1'b0, op, sum[3:0]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ula_a"},  8'(bus.ula_a), 8'h00);
    chk({tag, "_ula_b"},  8'(bus.ula_b), 8'h00);
    chk({tag, "_ula_op"}, 8'(bus.ula_op), 8'h00);
    chk({tag, "_rsp_s"},  bus.rsp_s, 8'h00);
    chk({tag, "_rsp_v0"}, 8'(bus.rsp_valid0), 8'h00);
    chk({tag, "_rsp_v1"}, 8'(bus.rsp_valid1), 8'h00);
    chk({tag, "_rdy0"},   8'(bus.req_ready0), 8'h00);
    chk({tag, "_rdy1"},   8'(bus.req_ready1), 8'h00);
    chk({tag, "_busy"},   8'(bus.busy), 8'h00);
  endtask

  // One complete transaction. It is entered just after a clock edge with the arbiter idle.
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] op0,
                         input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] op1,
                         input int unsigned hold, output logic w);
    logic [3:0] wa, wb;
    logic [2:0] wop;
    logic [7:0] exp_s;
    bus.req_valid0 = v0; bus.req_a0 = a0; bus.req_b0 = b0; bus.req_op0 = op0;
    bus.req_valid1 = v1; bus.req_a1 = a1; bus.req_b1 = b1; bus.req_op1 = op1;
    w     = (v0 && v1) ? m_prio : v1;
    wa    = w ? a1 : a0;
    wb    = w ? b1 : b0;
    wop   = w ? op1 : op0;
    exp_s = ula_ref(wa, wb, wop);
    #1;
    chk("idle_busy", 8'(bus.busy), 8'h00);
    chk("grant0", 8'(bus.req_ready0), 8'(!w));
    chk("grant1", 8'(bus.req_ready1), 8'(w));
    @(posedge clk); #1;
    if (w) bus.req_valid1 = 1'b0;
    else   bus.req_valid0 = 1'b0;
    chk("exec_busy", 8'(bus.busy), 8'h01);
    chk("exec_ula_a", 8'(bus.ula_a), 8'(wa));
    chk("exec_ula_b", 8'(bus.ula_b), 8'(wb));
    chk("exec_ula_op", 8'(bus.ula_op), 8'(wop));
    chk("exec_rdy", {6'b0, bus.req_ready1, bus.req_ready0}, 8'h00);
    chk("exec_rspv", {6'b0, bus.rsp_valid1, bus.rsp_valid0}, 8'h00);
    @(posedge clk); #1;
    for (int unsigned i = 0; i <= hold; i++) begin
      chk("resp_v0", 8'(bus.rsp_valid0), 8'(!w));
      chk("resp_v1", 8'(bus.rsp_valid1), 8'(w));
      chk("resp_s", bus.rsp_s, exp_s);
      chk("resp_rdy", {6'b0, bus.req_ready1, bus.req_ready0}, 8'h00);
      chk("resp_busy", 8'(bus.busy), 8'h01);
      // The non-owner's rsp_ready is toggled at random, since the arbiter must ignore it.
      if (w) begin
        bus.rsp_ready1 = (i == hold);
        bus.rsp_ready0 = 1'($urandom_range(0, 1));
      end else begin
        bus.rsp_ready0 = (i == hold);
        bus.rsp_ready1 = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready0 = 1'b0;
    bus.rsp_ready1 = 1'b0;
    m_prio = !w;
    chk("done_busy", 8'(bus.busy), 8'h00);
    chk("done_rspv", {6'b0, bus.rsp_valid1, bus.rsp_valid0}, 8'h00);
  endtask

  initial begin
    logic w;
    logic cv0, cv1;
    logic [3:0] ca0, cb0, ca1, cb1;
    logic [2:0] cop0, cop1;
    logic [2:0] opv;
    total = 0;
    bad   = 0;
    m_prio = 1'b0;
    rst_n = 1'b0;
    bus.req_valid0 = 1'b1; bus.req_a0 = 4'd9; bus.req_b0 = 4'd2; bus.req_op0 = 3'd5;
    bus.req_valid1 = 1'b0; bus.req_a1 = '0;   bus.req_b1 = '0;   bus.req_op1 = '0;
    bus.rsp_ready0 = 1'b0; bus.rsp_ready1 = 1'b0;

    // Reset is held for several edges with a valid request present. No ready may be raised.
    #2;
    chk_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por_hold");
    bus.req_valid0 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 8'(bus.busy), 8'h00);
    chk("post_rst_rdy", {6'b0, bus.req_ready1, bus.req_ready0}, 8'h00);

    // A simultaneous request after reset: req0 is served first, then req1.
    run_txn(1'b1, 1'b1, 4'd1, 4'd1, 3'd0, 4'd2, 4'd5, 3'd6, 0, w);
    chk("sim_first_owner", 8'(w), 8'h00);
    run_txn(1'b0, 1'b1, 4'd1, 4'd1, 3'd0, 4'd2, 4'd5, 3'd6, 0, w);
    chk("sim_second_owner", 8'(w), 8'h01);

    // A single request: 3 + 4 with op 4 gives 8'h47.
    run_txn(1'b1, 1'b0, 4'd3, 4'd4, 3'd4, 4'd0, 4'd0, 3'd0, 1, w);
    chk("single_s47", bus.rsp_s, 8'h47);

    // Both requesters are valid with prio = 1: req1 goes first, then req0. The sum wraps to 8'h40.
    run_txn(1'b1, 1'b1, 4'd15, 4'd1, 3'd4, 4'd7, 4'd7, 3'd1, 0, w);
    chk("rr_first_owner", 8'(w), 8'h01);
    run_txn(1'b1, 1'b0, 4'd15, 4'd1, 3'd4, 4'd7, 4'd7, 3'd1, 0, w);
    chk("wrap_s40", bus.rsp_s, 8'h40);

    // Req1 issues all 8 opcodes back-to-back while req0 is idle.
    for (int unsigned k = 0; k < 8; k++) begin
      opv = 3'(k);
      run_txn(1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 4'(k), 4'(k + 3), opv, 0, w);
      chk("op_sweep_owner", 8'(w), 8'h01);
    end

    // Back-pressure: req0 is held in RESP for 5 cycles while req1 waits. Then req1 is granted.
    run_txn(1'b1, 1'b1, 4'd6, 4'd5, 3'd2, 4'd8, 4'd8, 3'd7, 5, w);
    chk("bp_owner", 8'(w), 8'h00);
    chk("bp_next_grant1", 8'(bus.req_ready1), 8'h01);
    run_txn(1'b0, 1'b1, 4'd6, 4'd5, 3'd2, 4'd8, 4'd8, 3'd7, 0, w);
    chk("bp_second_owner", 8'(w), 8'h01);

    // Randomized traffic: a requester keeps its request pending until it is granted.
    cv0 = 1'b0; cv1 = 1'b0;
    ca0 = '0; cb0 = '0; cop0 = '0; ca1 = '0; cb1 = '0; cop1 = '0;
    for (int it = 0; it < 60; it++) begin
      if (!cv0 && $urandom_range(0, 2) != 0) begin
        cv0 = 1'b1; ca0 = 4'($urandom); cb0 = 4'($urandom); cop0 = 3'($urandom);
      end
      if (!cv1 && $urandom_range(0, 2) != 0) begin
        cv1 = 1'b1; ca1 = 4'($urandom); cb1 = 4'($urandom); cop1 = 3'($urandom);
      end
      if (!cv0 && !cv1) begin
        bus.req_valid0 = 1'b0;
        bus.req_valid1 = 1'b0;
        @(posedge clk); #1;
        chk("rnd_idle_busy", 8'(bus.busy), 8'h00);
        chk("rnd_idle_rdy", {6'b0, bus.req_ready1, bus.req_ready0}, 8'h00);
      end else begin
        run_txn(cv0, cv1, ca0, cb0, cop0, ca1, cb1, cop1, $urandom_range(0, 3), w);
        if (w) cv1 = 1'b0;
        else   cv0 = 1'b0;
      end
    end
    bus.req_valid0 = 1'b0;
    bus.req_valid1 = 1'b0;
    @(posedge clk); #1;

    // Reset asserted during RESP to req1: the response is dropped and prio returns to 0.
    bus.req_valid1 = 1'b1; bus.req_a1 = 4'd10; bus.req_b1 = 4'd3; bus.req_op1 = 3'd5;
    @(posedge clk); #1;
    bus.req_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_rspv1", 8'(bus.rsp_valid1), 8'h01);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    chk_reset_outputs("mid_rst_hold");
    rst_n = 1'b1;
    m_prio = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_idle_busy", 8'(bus.busy), 8'h00);
    chk("mid_rst_idle_rspv", {6'b0, bus.rsp_valid1, bus.rsp_valid0}, 8'h00);
    run_txn(1'b1, 1'b1, 4'd2, 4'd2, 3'd3, 4'd4, 4'd4, 3'd1, 0, w);
    chk("post_mid_rst_owner", 8'(w), 8'h00);
    run_txn(1'b0, 1'b1, 4'd2, 4'd2, 3'd3, 4'd4, 4'd4, 3'd1, 0, w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
